fusion_frame_scheduler: RTL and testbench

//   Sequences the multi-sensor fusion pipeline frame by frame. Gathers per-sensor decoder valid strobes

---
 rtl/fusion_sched_pkg.sv | 32 +++
 rtl/fusion_sat_counter.sv | 26 ++
 rtl/fusion_frame_scheduler.sv | 159 +++++++++++++++
 tb/tb_fusion_frame_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_sched_pkg.sv
// Shared types and constants for the fusion frame scheduler.
//   sched_state_e  : scheduler FSM states
//   frame_status_e : per-frame completion status reported with frame_done
//   ERR_*          : bit positions inside the sticky error_flags vector
//   SENSOR_*       : bit positions inside sensor_valid / fuse_mask
package fusion_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LAUNCH  = 2'd2,
    WAIT    = 2'd3
  } sched_state_e;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'd0,
    STATUS_PIPE_ERR = 2'd1,
    STATUS_TIMEOUT  = 2'd2
  } frame_status_e;

  localparam int NUM_ERR     = 4;
  localparam int ERR_DROP    = 0;
  localparam int ERR_TIMEOUT = 1;
  localparam int ERR_OVERRUN = 2;
  localparam int ERR_PIPE    = 3;

  localparam int SENSOR_CAM   = 0;
  localparam int SENSOR_LIDAR = 1;
  localparam int SENSOR_RADAR = 2;
  localparam int SENSOR_IMU   = 3;

endpackage

// File: rtl/fusion_sat_counter.sv
// Saturating up-counter used for the frame statistics.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear (wins over inc)
//   count      : current value, sticks at all-ones
module fusion_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fusion_frame_scheduler.sv
// Frame scheduler for the multi-sensor fusion pipeline.
// Collects per-sensor valid strobes inside a bounded window, launches the
// pipeline once per frame, waits for completion (with timeout) and reports
// per-frame status, sticky errors and saturating frame counters.
//   enable / clear_errors          : scheduler enable, sticky-error clear pulse
//   sensor_valid / timestamp       : decoder strobes and free-running time
//   pipe_done / pipe_error         : pipeline completion and its error flags
//   fuse_start / fuse_mask/fuse_ts : launch pulse plus frame descriptor
//   busy / frame_done/frame_status : activity, end-of-frame pulse and status
//   error_flags                    : sticky {pipe_err, overrun, timeout, drop}
//   frames_fused / frames_dropped  : saturating frame counters
module fusion_frame_scheduler
  import fusion_sched_pkg::*;
#(
  parameter int                     NUM_SENSORS   = 4,
  parameter logic [NUM_SENSORS-1:0] REQUIRED_MASK = 4'b0111,
  parameter int                     WINDOW_CYCLES = 1024,
  parameter int                     PIPE_TIMEOUT  = 4096,
  parameter int                     TS_W          = 64,
  parameter int                     CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear_errors,
  input  logic [NUM_SENSORS-1:0] sensor_valid,
  input  logic [TS_W-1:0]        timestamp,
  input  logic                   pipe_done,
  input  logic [7:0]             pipe_error,
  output logic                   fuse_start,
  output logic [NUM_SENSORS-1:0] fuse_mask,
  output logic [TS_W-1:0]        fuse_ts,
  output logic                   busy,
  output logic                   frame_done,
  output logic [1:0]             frame_status,
  output logic [NUM_ERR-1:0]     error_flags,
  output logic [CNT_W-1:0]       frames_fused,
  output logic [CNT_W-1:0]       frames_dropped
);

  localparam int              WIN_W    = $clog2(WINDOW_CYCLES);
  localparam int              TO_W     = $clog2(PIPE_TIMEOUT);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(PIPE_TIMEOUT - 1);

  sched_state_e           state;
  logic [WIN_W-1:0]       win_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic [NUM_SENSORS-1:0] merged_mask;
  logic                   req_met;
  logic                   drop_now;
  logic                   done_now;
  logic [NUM_ERR-1:0]     err_set;

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block leaves it unassigned (no latch).
    err_set     = '0;
    merged_mask = fuse_mask | sensor_valid;
    req_met     = (merged_mask & REQUIRED_MASK) == REQUIRED_MASK;
    // Launch takes priority over window expiry in the same cycle.
    drop_now    = (state == COLLECT) && enable && !req_met && (win_cnt == WIN_LAST);
    done_now    = (state == WAIT) && (pipe_done || (to_cnt == TO_LAST));

    err_set[ERR_DROP]    = drop_now;
    err_set[ERR_TIMEOUT] = (state == WAIT) && !pipe_done && (to_cnt == TO_LAST);
    // Strobes arriving while a frame is in flight are lost; flag them.
    err_set[ERR_OVERRUN] = ((state == LAUNCH) || (state == WAIT)) && (|sensor_valid);
    err_set[ERR_PIPE]    = (state == WAIT) && pipe_done && (|pipe_error);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      win_cnt      <= '0;
      to_cnt       <= '0;
      fuse_start   <= 1'b0;
      fuse_mask    <= '0;
      fuse_ts      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_status <= STATUS_OK;
      error_flags  <= '0;
    end else begin
      fuse_start  <= 1'b0;
      frame_done  <= 1'b0;
      // A new error raised in the clearing cycle survives the clear.
      error_flags <= (clear_errors ? '0 : error_flags) | err_set;

      unique case (state)
        IDLE: begin
          if (enable && (|sensor_valid)) begin
            fuse_mask <= sensor_valid;
            fuse_ts   <= timestamp;
            win_cnt   <= '0;
            busy      <= 1'b1;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (!enable) begin
            fuse_mask <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (req_met) begin
            fuse_mask  <= merged_mask;
            fuse_start <= 1'b1;
            state      <= LAUNCH;
          end else if (win_cnt == WIN_LAST) begin
            fuse_mask <= merged_mask;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            fuse_mask <= merged_mask;
            win_cnt   <= win_cnt + WIN_W'(1);
          end
        end
        LAUNCH: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // enable is deliberately ignored: a running pipeline is never aborted.
          if (pipe_done) begin
            frame_done   <= 1'b1;
            frame_status <= (|pipe_error) ? STATUS_PIPE_ERR : STATUS_OK;
            busy         <= 1'b0;
            state        <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            frame_done   <= 1'b1;
            frame_status <= STATUS_TIMEOUT;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fusion_sat_counter #(.WIDTH(CNT_W)) u_fused_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done_now),
    .clr   (1'b0),
    .count (frames_fused)
  );

  fusion_sat_counter #(.WIDTH(CNT_W)) u_dropped_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_now),
    .clr   (1'b0),
    .count (frames_dropped)
  );

endmodule

// File: tb/tb_fusion_frame_scheduler.sv
// Self-checking bench for fusion_frame_scheduler. Short window/timeout and a
// 4-bit counter width keep expiry and saturation cases within a short run.
module tb_fusion_frame_scheduler;

  localparam int NS    = 4;
  localparam int TS_W  = 64;
  localparam int CNT_W = 4;
  localparam int WIN   = 8;
  localparam int TMO   = 16;

  localparam int P_IDLE = 0, P_COLLECT = 1, P_LAUNCH = 2, P_WAIT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable = 1'b0;
  logic             clear_errors = 1'b0;
  logic [NS-1:0]    sensor_valid = '0;
  logic [TS_W-1:0]  timestamp = '0;
  logic             pipe_done = 1'b0;
  logic [7:0]       pipe_error = '0;
  logic             fuse_start;
  logic [NS-1:0]    fuse_mask;
  logic [TS_W-1:0]  fuse_ts;
  logic             busy;
  logic             frame_done;
  logic [1:0]       frame_status;
  logic [3:0]       error_flags;
  logic [CNT_W-1:0] frames_fused;
  logic [CNT_W-1:0] frames_dropped;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fusion_frame_scheduler #(
    .NUM_SENSORS   (NS),
    .REQUIRED_MASK (4'b0111),
    .WINDOW_CYCLES (WIN),
    .PIPE_TIMEOUT  (TMO),
    .TS_W          (TS_W),
    .CNT_W         (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .clear_errors   (clear_errors),
    .sensor_valid   (sensor_valid),
    .timestamp      (timestamp),
    .pipe_done      (pipe_done),
    .pipe_error     (pipe_error),
    .fuse_start     (fuse_start),
    .fuse_mask      (fuse_mask),
    .fuse_ts        (fuse_ts),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_status   (frame_status),
    .error_flags    (error_flags),
    .frames_fused   (frames_fused),
    .frames_dropped (frames_dropped)
  );

  // Reference model: frame phase plus cycles elapsed in that phase.
  int              m_phase;
  int              m_elapsed;
  logic [NS-1:0]   m_mask;
  logic [TS_W-1:0] m_ts;
  logic            m_start, m_done, m_busy;
  logic [1:0]      m_status;
  logic [3:0]      m_err;
  logic [3:0]      m_fused, m_dropped;

  task automatic model_reset();
    m_phase = P_IDLE; m_elapsed = 0; m_mask = '0; m_ts = '0;
    m_start = 0; m_done = 0; m_busy = 0; m_status = 0; m_err = 0;
    m_fused = 0; m_dropped = 0;
  endtask

  task automatic model_step();
    logic [3:0]    nerr;
    logic [NS-1:0] cm;
    nerr = 0; m_start = 0; m_done = 0;
    cm = m_mask | sensor_valid;
    case (m_phase)
      P_IDLE: if (enable && sensor_valid != 0) begin
        m_mask = sensor_valid; m_ts = timestamp; m_elapsed = 0; m_phase = P_COLLECT;
      end
      P_COLLECT: begin
        if (!enable) begin
          m_mask = '0; m_phase = P_IDLE;
        end else if ((cm & 4'b0111) == 4'b0111) begin
          m_mask = cm; m_start = 1; m_phase = P_LAUNCH;
        end else if (m_elapsed + 1 == WIN) begin
          m_mask = cm; nerr[0] = 1; m_phase = P_IDLE;
          if (m_dropped != 4'hF) m_dropped = m_dropped + 1;
        end else begin
          m_mask = cm; m_elapsed = m_elapsed + 1;
        end
      end
      P_LAUNCH: begin
        if (sensor_valid != 0) nerr[2] = 1;
        m_elapsed = 0; m_phase = P_WAIT;
      end
      default: begin
        if (sensor_valid != 0) nerr[2] = 1;
        if (pipe_done || (m_elapsed + 1 == TMO)) begin
          m_done = 1; m_phase = P_IDLE;
          if (m_fused != 4'hF) m_fused = m_fused + 1;
          if (pipe_done) begin
            m_status = (pipe_error != 0) ? 2'd1 : 2'd0;
            if (pipe_error != 0) nerr[3] = 1;
          end else begin
            m_status = 2'd2; nerr[1] = 1;
          end
        end else begin
          m_elapsed = m_elapsed + 1;
        end
      end
    endcase
    m_err  = (clear_errors ? 4'h0 : m_err) | nerr;
    m_busy = (m_phase != P_IDLE);
  endtask

  // One clock: model consumes the inputs the DUT sees at the edge; sample at edge+1.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; enable = 0; clear_errors = 0; sensor_valid = '0;
    pipe_done = 0; pipe_error = '0; timestamp = '0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    n_tests++; if ({fuse_start, busy, frame_done, frame_status} !== 5'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {fuse_start, busy, frame_done, frame_status}); end
    n_tests++; if ({fuse_mask, error_flags} !== 8'h00) begin n_fail++;
      $display("FAIL reset_mask_err: got %h want 00", {fuse_mask, error_flags}); end
    n_tests++; if (fuse_ts !== '0) begin n_fail++;
      $display("FAIL reset_ts: got %0d want 0", fuse_ts); end
    n_tests++; if ({frames_fused, frames_dropped} !== 8'h00) begin n_fail++;
      $display("FAIL reset_counters: got %h want 00", {frames_fused, frames_dropped}); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_launch_latency();
    do_reset();
    enable = 1; timestamp = 100; sensor_valid = 4'b0111;
    cycle();
    sensor_valid = 0; timestamp = 101;
    n_tests++; if ({fuse_start, busy} !== 2'b01) begin n_fail++;
      $display("FAIL latency_n1: start,busy got %b want 01", {fuse_start, busy}); end
    cycle();
    n_tests++; if (fuse_start !== 1'b1) begin n_fail++;
      $display("FAIL latency_n2: fuse_start got %b want 1", fuse_start); end
    n_tests++; if (fuse_mask !== 4'b0111 || fuse_ts !== 64'd100) begin n_fail++;
      $display("FAIL latency_desc: mask %b ts %0d want 0111 100", fuse_mask, fuse_ts); end
    cycle();
    n_tests++; if ({fuse_start, busy} !== 2'b01) begin n_fail++;
      $display("FAIL latency_pulse: start,busy got %b want 01", {fuse_start, busy}); end
    pipe_done = 1; cycle(); pipe_done = 0;
  endtask

  task automatic test_staggered_ok();
    do_reset();
    enable = 1; timestamp = 500; sensor_valid = 4'b0001;
    cycle();
    sensor_valid = 0; timestamp = 600;
    repeat (4) cycle();
    sensor_valid = 4'b0100; cycle(); sensor_valid = 0;
    repeat (2) cycle();
    // Lidar lands on the last window cycle: launch must beat the drop.
    sensor_valid = 4'b0010; cycle(); sensor_valid = 0;
    n_tests++; if (fuse_start !== 1'b1 || fuse_mask !== 4'b0111 || fuse_ts !== 64'd500) begin n_fail++;
      $display("FAIL stagger_launch: start %b mask %b ts %0d want 1 0111 500", fuse_start, fuse_mask, fuse_ts); end
    cycle();
    repeat (9) cycle();
    pipe_done = 1; pipe_error = 0; cycle(); pipe_done = 0;
    n_tests++; if ({frame_done, busy, frame_status} !== 4'b1000) begin n_fail++;
      $display("FAIL stagger_done: done,busy,status got %b want 1000", {frame_done, busy, frame_status}); end
    n_tests++; if (frames_fused !== 4'd1 || error_flags !== 4'b0000 || frames_dropped !== 4'd0) begin n_fail++;
      $display("FAIL stagger_counts: fused %0d err %b dropped %0d want 1 0000 0", frames_fused, error_flags, frames_dropped); end
    cycle();
    n_tests++; if (frame_done !== 1'b0) begin n_fail++;
      $display("FAIL stagger_pulse: frame_done got %b want 0", frame_done); end
  endtask

  task automatic test_window_drop();
    int starts;
    starts = 0;
    do_reset();
    enable = 1; sensor_valid = 4'b1001;
    cycle();
    for (int i = 0; i < WIN - 1; i++) begin
      sensor_valid = (i == 3) ? 4'b1000 : 4'b0000;
      cycle();
      if (fuse_start) starts++;
    end
    sensor_valid = 0;
    n_tests++; if (busy !== 1'b1) begin n_fail++;
      $display("FAIL drop_early: busy got %b want 1", busy); end
    cycle();
    if (fuse_start) starts++;
    n_tests++; if (busy !== 1'b0 || frames_dropped !== 4'd1 || error_flags !== 4'b0001) begin n_fail++;
      $display("FAIL drop_expire: busy %b dropped %0d err %b want 0 1 0001", busy, frames_dropped, error_flags); end
    n_tests++; if (starts != 0 || frames_fused !== 4'd0) begin n_fail++;
      $display("FAIL drop_nostart: starts %0d fused %0d want 0 0", starts, frames_fused); end
    clear_errors = 1; cycle(); clear_errors = 0;
    n_tests++; if (error_flags !== 4'b0000) begin n_fail++;
      $display("FAIL drop_clear: err got %b want 0000", error_flags); end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    do_reset();
    enable = 1; sensor_valid = 4'b0111; cycle(); sensor_valid = 0;
    cycle(); cycle();
    repeat (TMO - 1) begin cycle(); if (frame_done) early++; end
    n_tests++; if (early != 0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL timeout_early: early %0d busy %b want 0 1", early, busy); end
    cycle();
    n_tests++; if ({frame_done, frame_status} !== 3'b110 || error_flags !== 4'b0010 || frames_fused !== 4'd1) begin n_fail++;
      $display("FAIL timeout_fire: done,status %b err %b fused %0d want 110 0010 1", {frame_done, frame_status}, error_flags, frames_fused); end
    // pipe_done on the timeout cycle wins.
    sensor_valid = 4'b0111; cycle(); sensor_valid = 0;
    cycle(); cycle();
    repeat (TMO - 1) cycle();
    pipe_done = 1; cycle(); pipe_done = 0;
    n_tests++; if ({frame_done, frame_status} !== 3'b100 || error_flags !== 4'b0010 || frames_fused !== 4'd2) begin n_fail++;
      $display("FAIL timeout_tie: done,status %b err %b fused %0d want 100 0010 2", {frame_done, frame_status}, error_flags, frames_fused); end
  endtask

  task automatic test_overrun_pipe_err();
    do_reset();
    enable = 1; timestamp = 777; sensor_valid = 4'b0111; cycle(); sensor_valid = 0; timestamp = 0;
    cycle(); cycle();
    sensor_valid = 4'b0010; cycle(); sensor_valid = 0;
    n_tests++; if (error_flags !== 4'b0100) begin n_fail++;
      $display("FAIL overrun_flag: err got %b want 0100", error_flags); end
    repeat (3) cycle();
    pipe_done = 1; pipe_error = 8'h03; cycle(); pipe_done = 0; pipe_error = 0;
    n_tests++; if (error_flags !== 4'b1100 || {frame_done, frame_status} !== 3'b101) begin n_fail++;
      $display("FAIL pipe_err: err %b done,status %b want 1100 101", error_flags, {frame_done, frame_status}); end
    n_tests++; if (fuse_mask !== 4'b0111 || fuse_ts !== 64'd777) begin n_fail++;
      $display("FAIL pipe_err_desc: mask %b ts %0d want 0111 777", fuse_mask, fuse_ts); end
    pipe_done = 1; cycle(); pipe_done = 0;
    n_tests++; if (frame_done !== 1'b0 || frames_fused !== 4'd1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL spurious_done: done %b fused %0d busy %b want 0 1 0", frame_done, frames_fused, busy); end
    sensor_valid = 4'b0111; cycle(); sensor_valid = 0;
    cycle();
    sensor_valid = 4'b1000; clear_errors = 1; cycle(); sensor_valid = 0; clear_errors = 0;
    n_tests++; if (error_flags !== 4'b0100) begin n_fail++;
      $display("FAIL clear_vs_new: err got %b want 0100", error_flags); end
    clear_errors = 1; cycle(); clear_errors = 0;
    n_tests++; if (error_flags !== 4'b0000) begin n_fail++;
      $display("FAIL clear_only: err got %b want 0000", error_flags); end
    pipe_done = 1; cycle(); pipe_done = 0;
  endtask

  task automatic test_disable();
    do_reset();
    enable = 1; timestamp = 42; sensor_valid = 4'b0001; cycle(); sensor_valid = 0;
    cycle();
    enable = 0; cycle();
    n_tests++; if (busy !== 1'b0 || fuse_mask !== 4'b0000 || frames_dropped !== 4'd0 || error_flags !== 4'b0) begin n_fail++;
      $display("FAIL disable_abort: busy %b mask %b dropped %0d err %b want 0 0000 0 0000", busy, fuse_mask, frames_dropped, error_flags); end
    enable = 1; sensor_valid = 4'b0111; cycle(); sensor_valid = 0;
    cycle(); cycle();
    enable = 0; repeat (3) cycle();
    n_tests++; if (busy !== 1'b1) begin n_fail++;
      $display("FAIL disable_wait: busy got %b want 1", busy); end
    pipe_done = 1; cycle(); pipe_done = 0;
    n_tests++; if (frame_done !== 1'b1 || frames_fused !== 4'd1) begin n_fail++;
      $display("FAIL disable_done: done %b fused %0d want 1 1", frame_done, frames_fused); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    enable = 1; timestamp = 9; sensor_valid = 4'b0111; cycle(); sensor_valid = 0;
    cycle(); cycle();
    sensor_valid = 4'b0100; cycle(); sensor_valid = 0;
    #3 rst_n = 0;
    #1;
    n_tests++; if ({busy, fuse_mask, error_flags, frame_status} !== 11'b0 || fuse_ts !== '0) begin n_fail++;
      $display("FAIL reset_async: busy %b mask %b err %b status %b ts %0d want all 0", busy, fuse_mask, error_flags, frame_status, fuse_ts); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    cycle();
    n_tests++; if (busy !== 1'b0 || fuse_start !== 1'b0) begin n_fail++;
      $display("FAIL reset_idle: busy %b start %b want 0 0", busy, fuse_start); end
  endtask

  task automatic test_saturation();
    do_reset();
    enable = 1;
    for (int k = 0; k < 17; k++) begin
      sensor_valid = 4'b0001; cycle(); sensor_valid = 0;
      repeat (WIN) cycle();
    end
    n_tests++; if (frames_dropped !== 4'hF) begin n_fail++;
      $display("FAIL sat_dropped: got %h want F", frames_dropped); end
    for (int k = 0; k < 17; k++) begin
      sensor_valid = 4'b0111; cycle(); sensor_valid = 0;
      cycle(); cycle();
      pipe_done = 1; cycle(); pipe_done = 0;
    end
    n_tests++; if (frames_fused !== 4'hF) begin n_fail++;
      $display("FAIL sat_fused: got %h want F", frames_fused); end
  endtask

  task automatic test_random();
    logic [19:0] got, exp;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 31) != 0);
      for (int j = 0; j < NS; j++) sensor_valid[j] = ($urandom_range(0, 7) == 0);
      pipe_done    = ($urandom_range(0, 9) == 0);
      pipe_error   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      clear_errors = ($urandom_range(0, 31) == 0);
      timestamp    = {$urandom, $urandom};
      cycle();
      got = {fuse_start, fuse_mask, busy, frame_done, frame_status, error_flags, frames_fused, frames_dropped};
      exp = {m_start, m_mask, m_busy, m_done, m_status, m_err, m_fused, m_dropped};
      n_tests++; if (got !== exp) begin n_fail++;
        $display("FAIL random_outputs cycle %0d: got %h want %h", i, got, exp); end
      n_tests++; if (fuse_ts !== m_ts) begin n_fail++;
        $display("FAIL random_ts cycle %0d: got %h want %h", i, fuse_ts, m_ts); end
    end
    enable = 0; sensor_valid = 0; pipe_done = 0; clear_errors = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_launch_latency();
    test_staggered_ok();
    test_window_drop();
    test_timeout();
    test_overrun_pipe_err();
    test_disable();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
